// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare/BTB branch predictor:
//   - PHT counter constants (weakly-not-taken reset value, saturation ceiling)
//   - PHT index mode enumeration
//   - two-bit saturating counter helpers
// No ports (package).
// ----------------------------------------------------------------------------
package bp_pkg;

  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_MAX = 2'b11;

  typedef enum logic {
    IDX_GLOBAL = 1'b0,
    IDX_GSHARE = 1'b1
  } idx_mode_e;

  function automatic logic [1:0] sat_inc2(input logic [1:0] cnt);
    return (cnt == PHT_MAX) ? PHT_MAX : cnt + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] cnt);
    return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/btb_lru_cam.sv
// ----------------------------------------------------------------------------
// btb_lru_cam
// Fully associative branch target buffer with true-LRU replacement.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   lookup_pc_i  fetch PC to match against stored tags
//   hit_o        a valid entry matches lookup_pc_i
//   target_o     target of the matching entry, zero on miss
//   wr_en_i      train with a taken branch this cycle
//   wr_pc_i      branch PC (tag) being trained
//   wr_target_i  resolved target written into the entry
// ----------------------------------------------------------------------------
module btb_lru_cam #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] target_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_pc_i,
  input  logic [ADDR_W-1:0] wr_target_i
);

  localparam int AW = $clog2(ENTRIES);
  localparam logic [AW-1:0] AGE_OLDEST = AW'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [AW-1:0]      age_q    [ENTRIES];
  logic [AW-1:0]      age_d    [ENTRIES];

  logic          match_found_s, free_found_s;
  logic [AW-1:0] match_idx_s, free_idx_s, lru_idx_s, sel_idx_s, old_age_s;

  // Lookup: tags are unique, so OR-ing masked targets yields the single match.
  always_comb begin
    hit_o    = 1'b0;
    target_o = {ADDR_W{1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      hit_o    = hit_o | (valid_q[i] & (tag_q[i] == lookup_pc_i));
      target_o = target_o | (target_q[i] & {ADDR_W{valid_q[i] & (tag_q[i] == lookup_pc_i)}});
    end
  end

  // Training slot: existing tag, else lowest invalid entry, else the oldest one.
  always_comb begin
    match_found_s = 1'b0;
    free_found_s  = 1'b0;
    match_idx_s   = {AW{1'b0}};
    free_idx_s    = {AW{1'b0}};
    lru_idx_s     = {AW{1'b0}};
    // Scan downwards so the lowest-index free entry is the last one recorded.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      match_found_s = match_found_s | (valid_q[i] & (tag_q[i] == wr_pc_i));
      match_idx_s   = (valid_q[i] && (tag_q[i] == wr_pc_i)) ? AW'(i) : match_idx_s;
      free_found_s  = free_found_s | ~valid_q[i];
      free_idx_s    = (!valid_q[i]) ? AW'(i) : free_idx_s;
      // Ages are a permutation, so the oldest entry carries age ENTRIES-1.
      lru_idx_s     = (age_q[i] == AGE_OLDEST) ? AW'(i) : lru_idx_s;
    end
    sel_idx_s = match_found_s ? match_idx_s : (free_found_s ? free_idx_s : lru_idx_s);
    old_age_s = age_q[sel_idx_s];
  end

  // Next state: write the selected slot, make it MRU, age the younger entries.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    age_d    = age_q;
    if (wr_en_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (AW'(i) == sel_idx_s) begin
          valid_d[i]  = 1'b1;
          tag_d[i]    = wr_pc_i;
          target_d[i] = wr_target_i;
          age_d[i]    = {AW{1'b0}};
        end else if (age_q[i] < old_age_s) begin
          age_d[i] = age_q[i] + AW'(1);
        end else begin
          age_d[i] = age_q[i];
        end
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset; initial ages form the permutation 0..N-1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= {ADDR_W{1'b0}};
        target_q[i] <= {ADDR_W{1'b0}};
        age_q[i]    <= AW'(i);
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// ----------------------------------------------------------------------------
// gshare_btb_predictor
// Fetch-stage branch predictor (global history / gshare PHT plus LRU BTB)
// trained from the execute stage.
// Ports:
//   CLK, RESET             clock, synchronous active-low reset
//   pc_f                   fetch PC
//   hit_f, pred_taken_f    BTB hit, PHT counter MSB
//   pred_redirect_f        redirect fetch (hit and predicted taken)
//   pred_target_f          predicted target, zero on miss
//   pred_idx_f             PHT index used, carried to execute
//   upd_*_e                execute-stage resolution of a branch
//   mispredict_e           resolution disagrees with the carried prediction
//   br_cnt, mp_cnt         saturating branch / mispredict counters
//   ghr                    global history register
// ----------------------------------------------------------------------------
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int GHR_W       = 3,
  parameter int BTB_ENTRIES = 4,
  parameter int INDEX_MODE  = 1,
  parameter int STAT_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] pc_f,
  output logic              hit_f,
  output logic              pred_taken_f,
  output logic              pred_redirect_f,
  output logic [ADDR_W-1:0] pred_target_f,
  output logic [GHR_W-1:0]  pred_idx_f,
  input  logic              upd_valid_e,
  input  logic              upd_taken_e,
  input  logic [ADDR_W-1:0] upd_pc_e,
  input  logic [ADDR_W-1:0] upd_target_e,
  input  logic [GHR_W-1:0]  upd_idx_e,
  input  logic              upd_pred_redirect_e,
  input  logic [ADDR_W-1:0] upd_pred_target_e,
  output logic              mispredict_e,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mp_cnt,
  output logic [GHR_W-1:0]  ghr
);

  localparam int PHT_N = 1 << GHR_W;
  localparam idx_mode_e MODE = idx_mode_e'(INDEX_MODE[0]);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [1:0]        pht_q [PHT_N];
  logic [1:0]        pht_d [PHT_N];
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  logic [GHR_W-1:0]  idx_s;

  // Fetch-side PHT index; gshare folds in word-aligned PC bits.
  always_comb begin
    if (MODE == IDX_GSHARE) begin
      idx_s = ghr_q ^ pc_f[GHR_W+1:2];
    end else begin
      idx_s = ghr_q;
    end
  end

  assign pred_idx_f      = idx_s;
  assign pred_taken_f    = pht_q[idx_s][1];
  assign pred_redirect_f = hit_f & pred_taken_f;

  btb_lru_cam #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .lookup_pc_i (pc_f),
    .hit_o       (hit_f),
    .target_o    (pred_target_f),
    .wr_en_i     (upd_valid_e & upd_taken_e),
    .wr_pc_i     (upd_pc_e),
    .wr_target_i (upd_target_e)
  );

  assign mispredict_e = upd_valid_e &
                        ((upd_taken_e != upd_pred_redirect_e) |
                         (upd_taken_e & (upd_target_e != upd_pred_target_e)));

  // History, PHT and statistics next state; PHT uses the index carried from fetch.
  always_comb begin
    ghr_d    = ghr_q;
    pht_d    = pht_q;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd_valid_e) begin
      // Shift form stays legal for GHR_W == 1.
      ghr_d = (ghr_q << 1) | GHR_W'(upd_taken_e);
      if (upd_taken_e) begin
        pht_d[upd_idx_e] = sat_inc2(pht_q[upd_idx_e]);
      end else begin
        pht_d[upd_idx_e] = sat_dec2(pht_q[upd_idx_e]);
      end
      br_cnt_d = (br_cnt_q == STAT_MAX) ? STAT_MAX : br_cnt_q + STAT_W'(1);
      if (mispredict_e) begin
        mp_cnt_d = (mp_cnt_q == STAT_MAX) ? STAT_MAX : mp_cnt_q + STAT_W'(1);
      end else begin
        mp_cnt_d = mp_cnt_q;
      end
    end else begin
      ghr_d = ghr_q;
    end
  end

  // State registers; reset takes priority over a same-cycle update.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ghr_q    <= {GHR_W{1'b0}};
      br_cnt_q <= {STAT_W{1'b0}};
      mp_cnt_q <= {STAT_W{1'b0}};
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= PHT_WNT;
      end
    end else begin
      ghr_q    <= ghr_d;
      pht_q    <= pht_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign ghr    = ghr_q;
  assign br_cnt = br_cnt_q;
  assign mp_cnt = mp_cnt_q;

endmodule
